// File: rtl/cordic_vector_9bit.sv
// -----------------------------------------------------------------------------
// cordic_vector_9bit
//
// Iterative CORDIC vectoring engine for the 9-bit Cartesian-to-polar path.
// A signed (X,Y) pair is rotated onto the positive x axis one micro-rotation
// per clock.  The result is an unscaled magnitude (CORDIC gain ~1.647 still
// present, removed by the downstream gain-compensation scaler) and a binary
// angle.
//
// Ports:
//   Clk      in   rising-edge clock
//   Rst      in   synchronous active-high reset
//   Start    in   request a conversion (honoured in IDLE and FIN only)
//   X_in     in   signed 9-bit X
//   Y_in     in   signed 9-bit Y
//   Busy     out  high while iterating
//   Done     out  one-cycle pulse, Mag_raw/Ang/Ovf valid
//   Mag_raw  out  unscaled magnitude 0..255
//   Ang      out  signed binary angle, 1 LSB = 180/256 deg
//   Ovf      out  magnitude saturated on this result
// -----------------------------------------------------------------------------
module cordic_vector_9bit #(
   parameter int ITER = 8,
   parameter int IW   = 12
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic signed [8:0] X_in,
   input  logic signed [8:0] Y_in,
   output logic              Busy,
   output logic              Done,
   output logic        [8:0] Mag_raw,
   output logic signed [8:0] Ang,
   output logic              Ovf
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic signed [IW-1:0] MAG_MAX = IW'(255);
   localparam logic        [3:0]    ITER_LAST = 4'(ITER - 1);

   // atan(2^-i) in binary-angle units (256 = 180 deg)
   function automatic logic signed [9:0] atan_lut(input logic [3:0] i);
      case (i)
         4'd0:    return 10'sd64;
         4'd1:    return 10'sd38;
         4'd2:    return 10'sd20;
         4'd3:    return 10'sd10;
         4'd4:    return 10'sd5;
         4'd5:    return 10'sd3;
         4'd6:    return 10'sd1;
         4'd7:    return 10'sd1;
         default: return 10'sd0;
      endcase
   endfunction

   // Returns {ovf, mag}; clamps to 255 above the 9-bit unsigned range.
   function automatic logic [9:0] sat_mag(input logic signed [IW-1:0] v);
      if (v > MAG_MAX)
         return {1'b1, 9'd255};
      else if (v[IW-1])
         return {1'b0, 9'd0};
      else
         return {1'b0, v[8:0]};
   endfunction

   logic [1:0]           state_q;
   logic [3:0]           iter_q;
   logic signed [IW-1:0] x_q, y_q;
   logic signed [9:0]    z_q;
   logic                 zero_q;

   logic signed [IW-1:0] x_ext, y_ext, x_pre, y_pre;
   logic signed [9:0]    z_pre;
   logic signed [IW-1:0] x_shr, y_shr, x_nx, y_nx;
   logic signed [9:0]    z_nx, step;
   logic [9:0]           sat_res;
   logic                 capture;

   assign Busy    = (state_q == S_RUN);
   assign Done    = (state_q == S_FIN);
   assign capture = Start && (state_q != S_RUN);

   // Capture: fold the left half-plane onto the right by a 180 deg
   // pre-rotation so the iterations only need to cover +/-90 deg.
   // -256 negates to +256, which IW bits hold without overflow.
   always_comb begin
      x_ext = {{(IW-9){X_in[8]}}, X_in};
      y_ext = {{(IW-9){Y_in[8]}}, Y_in};
      x_pre = x_ext;
      y_pre = y_ext;
      z_pre = 10'sd0;
      if (X_in[8]) begin
         x_pre = -x_ext;
         y_pre = -y_ext;
         z_pre = -10'sd256;
      end
   end

   // Micro-rotation i; both updates use the pre-update x/y.
   always_comb begin
      x_shr = x_q >>> iter_q;
      y_shr = y_q >>> iter_q;
      step  = atan_lut(iter_q);
      if (!y_q[IW-1]) begin
         x_nx = x_q + y_shr;
         y_nx = y_q - x_shr;
         z_nx = z_q + step;
      end else begin
         x_nx = x_q - y_shr;
         y_nx = y_q + x_shr;
         z_nx = z_q - step;
      end
      sat_res = sat_mag(x_nx);
   end

   // Datapath registers: no reset, only meaningful while a conversion runs.
   always_ff @(posedge Clk) begin
      if (capture) begin
         x_q    <= x_pre;
         y_q    <= y_pre;
         z_q    <= z_pre;
         zero_q <= (X_in == 9'sd0) && (Y_in == 9'sd0);
      end else if (state_q == S_RUN) begin
         x_q <= x_nx;
         y_q <= y_nx;
         z_q <= z_nx;
      end
   end

   // Control and result registers.  Results are loaded on the final
   // iteration so they are valid throughout the FIN (Done) cycle and hold
   // until the next one.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_IDLE;
         iter_q  <= 4'd0;
         Mag_raw <= 9'd0;
         Ang     <= 9'sd0;
         Ovf     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               iter_q <= 4'd0;
               if (Start) state_q <= S_RUN;
            end
            S_RUN: begin
               iter_q <= iter_q + 4'd1;
               if (iter_q == ITER_LAST) begin
                  state_q <= S_FIN;
                  if (zero_q) begin
                     // A zero vector has no meaningful angle
                     Mag_raw <= 9'd0;
                     Ang     <= 9'sd0;
                     Ovf     <= 1'b0;
                  end else begin
                     Mag_raw <= sat_res[8:0];
                     Ovf     <= sat_res[9];
                     // Angle wraps modulo 512 so +/-180 deg crossings fold
                     Ang     <= z_nx[8:0];
                  end
               end
            end
            S_FIN: begin
               iter_q  <= 4'd0;
               state_q <= Start ? S_RUN : S_IDLE;
            end
            default: begin
               iter_q  <= 4'd0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vector_9bit.sv
module tb_cordic_vector_9bit;

   logic              Clk = 1'b0;
   logic              Rst;
   logic              Start;
   logic signed [8:0] X_in;
   logic signed [8:0] Y_in;
   logic              Busy;
   logic              Done;
   logic        [8:0] Mag_raw;
   logic signed [8:0] Ang;
   logic              Ovf;

   cordic_vector_9bit dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .X_in(X_in), .Y_in(Y_in),
      .Busy(Busy), .Done(Done), .Mag_raw(Mag_raw), .Ang(Ang), .Ovf(Ovf)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      int    mag;
      int    mag_tol;
      int    ang;
      int    ang_tol;
      bit    ovf;
      int    done_cyc;
      string name;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int fails  = 0;

   task automatic check(input bit ok, input string nm, input int act, input int req);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   function automatic bit mag_ok(input int act, input int req, input int tol);
      int d;
      d = act - req;
      return (d >= -tol) && (d <= tol);
   endfunction

   // Angle distance measured modulo 512 so -256 and 255 are 1 LSB apart
   function automatic bit ang_ok(input int act, input int req, input int tol);
      logic signed [8:0] d;
      d = 9'(act - req);
      return (int'(d) >= -tol) && (int'(d) <= tol);
   endfunction

   // Scoreboard monitor
   always @(negedge Clk) begin
      if (Done) begin
         check(q.size() != 0, "done_expected", q.size(), 1);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check(cyc == e.done_cyc, {e.name, "_latency"}, cyc, e.done_cyc);
            check(mag_ok(int'(Mag_raw), e.mag, e.mag_tol), {e.name, "_mag"}, int'(Mag_raw), e.mag);
            check(ang_ok(int'(Ang), e.ang, e.ang_tol), {e.name, "_ang"}, int'(Ang), e.ang);
            check(Ovf == e.ovf, {e.name, "_ovf"}, int'(Ovf), int'(e.ovf));
            check(Busy == 1'b0, {e.name, "_busy_at_done"}, int'(Busy), 0);
         end
      end
   end

   task automatic push_exp(input string nm, input int mag, input int mtol,
                           input int ang, input int atol, input bit ovf, input int dc);
      exp_t e;
      e.name = nm; e.mag = mag; e.mag_tol = mtol; e.ang = ang; e.ang_tol = atol;
      e.ovf = ovf; e.done_cyc = dc;
      q.push_back(e);
   endtask

   // Pulse Start for one cycle; returns #1 into the following cycle.
   task automatic issue(input string nm, input int x, input int y, input int mag,
                        input int mtol, input int ang, input int atol, input bit ovf);
      @(posedge Clk); #1;
      X_in  = 9'(x);
      Y_in  = 9'(y);
      Start = 1'b1;
      push_exp(nm, mag, mtol, ang, atol, ovf, cyc + 9);
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 40 && q.size() != 0; t++) @(posedge Clk);
      check(q.size() == 0, "scoreboard_drain", q.size(), 0);
      q.delete();
      @(posedge Clk); #1;
   endtask

   task automatic step_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      Rst = 1'b1; Start = 1'b0; X_in = '0; Y_in = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check(Busy == 1'b0,   "reset_busy", int'(Busy), 0);
      check(Done == 1'b0,   "reset_done", int'(Done), 0);
      check(Mag_raw == 9'd0, "reset_mag", int'(Mag_raw), 0);
      check(Ang == 9'sd0,   "reset_ang",  int'(Ang), 0);
      check(Ovf == 1'b0,    "reset_ovf",  int'(Ovf), 0);
      @(posedge Clk); #1;
      Rst = 1'b0;

      // (100,0): Busy high for cycles 1..8 after Start, low in the Done cycle
      issue("v100_0", 100, 0, 165, 2, 0, 2, 1'b0);
      for (int j = 1; j <= 9; j++) begin
         @(negedge Clk);
         check(Busy == (j <= 8), $sformatf("busy_cycle%0d", j), int'(Busy), int'(j <= 8));
      end
      wait_drain();

      // (0,100) with a Start pulse and new inputs during RUN cycle 3
      issue("v0_100", 0, 100, 165, 2, 128, 2, 1'b0);
      step_cycles(2);
      Start = 1'b1; X_in = -9'sd60; Y_in = -9'sd60;
      step_cycles(1);
      Start = 1'b0;
      wait_drain();

      issue("vm60_m60", -60, -60, 140, 2, -192, 2, 1'b0);
      wait_drain();
      issue("vm100_1", -100, 1, 165, 2, 255, 2, 1'b0);
      wait_drain();
      issue("v200_200", 200, 200, 255, 0, 64, 2, 1'b1);
      wait_drain();
      issue("vm256_0", -256, 0, 255, 0, -256, 2, 1'b1);
      wait_drain();
      issue("v0_0", 0, 0, 0, 0, 0, 0, 1'b0);
      wait_drain();

      // Back-to-back: Start held through FIN
      @(posedge Clk); #1;
      k = cyc;
      X_in = 9'sd100; Y_in = 9'sd0; Start = 1'b1;
      push_exp("b2b_first", 165, 2, 0, 2, 1'b0, k + 9);
      push_exp("b2b_second", 255, 0, 64, 2, 1'b1, k + 18);
      step_cycles(1);
      X_in = 9'sd200; Y_in = 9'sd200;
      for (int t = 0; t < 20 && cyc < k + 9; t++) step_cycles(1);
      step_cycles(1);
      Start = 1'b0;
      step_cycles(3);
      @(negedge Clk);
      check(mag_ok(int'(Mag_raw), 165, 2), "hold_mag", int'(Mag_raw), 165);
      check(ang_ok(int'(Ang), 0, 2), "hold_ang", int'(Ang), 0);
      check(Ovf == 1'b0, "hold_ovf", int'(Ovf), 0);
      check(Busy == 1'b1, "hold_busy", int'(Busy), 1);
      wait_drain();

      // Reset during RUN cycle 5: aborted, no Done
      issue("aborted", 100, 0, 165, 2, 0, 2, 1'b0);
      step_cycles(4);
      Rst = 1'b1;
      void'(q.pop_back());
      @(negedge Clk);
      @(negedge Clk);
      check(Busy == 1'b0,    "abort_busy", int'(Busy), 0);
      check(Done == 1'b0,    "abort_done", int'(Done), 0);
      check(Mag_raw == 9'd0, "abort_mag", int'(Mag_raw), 0);
      check(Ang == 9'sd0,    "abort_ang", int'(Ang), 0);
      check(Ovf == 1'b0,     "abort_ovf", int'(Ovf), 0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      step_cycles(12);
      issue("after_reset", -60, -60, 140, 2, -192, 2, 1'b0);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
